// File: rtl/song_pkg.sv
// Shared types and constants for the song ROM walker (note_sequencer).
package song_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    WAIT
  } seq_state_t;

  // ROM word layout at the default 8-bit pitch / 8-bit duration widths.
  typedef struct packed {
    logic [7:0] pitch;
    logic [7:0] dur;
  } note_t;

  localparam int REST_PITCH = 0;
  localparam int END_DUR    = 0;

endpackage

// File: rtl/note_sequencer.sv
// Walks a song ROM of {pitch, dur} words, handing each note to the duration timer and tone stage.
// Build option LOOP_SONG_EN: restart from address 0 at the end marker/wrap instead of going idle.
//
// state | meaning
// IDLE  | not playing, waits for play
// FETCH | rom_addr stable, covering the one-cycle ROM latency
// LATCH | rom_data valid: end marker or load dur/pitch
// START | note_start pulse, tone enabled for non-rest notes
// WAIT  | note sounding until dur_done
module note_sequencer
  import song_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int PITCH_W = 8,
  parameter int DUR_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     play,
  input  logic                     stop,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [PITCH_W+DUR_W-1:0] rom_data,
  output logic [DUR_W-1:0]         dur,
  output logic                     note_start,
  input  logic                     dur_done,
  output logic [PITCH_W-1:0]       pitch,
  output logic                     tone_en,
  output logic                     playing,
  output logic                     song_end
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  seq_state_t           state;
  logic [DUR_W-1:0]     rom_dur;
  logic [PITCH_W-1:0]   rom_pitch;
  logic                 at_end;

  assign rom_dur   = rom_data[DUR_W-1:0];
  assign rom_pitch = rom_data[PITCH_W+DUR_W-1:DUR_W];

  // The last address finishing is treated exactly like reading an end marker.
  assign at_end = ((state == LATCH) && (rom_dur == DUR_W'(END_DUR))) ||
                  ((state == WAIT) && dur_done && (rom_addr == ADDR_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      dur        <= '0;
      pitch      <= '0;
      note_start <= 1'b0;
      tone_en    <= 1'b0;
      playing    <= 1'b0;
      song_end   <= 1'b0;
    end else begin
      note_start <= 1'b0;
      song_end   <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        tone_en <= 1'b0;
        playing <= 1'b0;
        dur     <= '0;
        pitch   <= '0;
      end else if (at_end) begin
        song_end <= 1'b1;
        tone_en  <= 1'b0;
`ifdef LOOP_SONG_EN
        rom_addr <= '0;
        state    <= FETCH;
`else
        state    <= IDLE;
        playing  <= 1'b0;
        dur      <= '0;
        pitch    <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (play) begin
              rom_addr <= '0;
              playing  <= 1'b1;
              state    <= FETCH;
            end
          end
          FETCH: state <= LATCH;
          LATCH: begin
            dur        <= rom_dur;
            pitch      <= rom_pitch;
            note_start <= 1'b1;
            tone_en    <= (rom_pitch != PITCH_W'(REST_PITCH));
            state      <= START;
          end
          // dur_done is still high from the previous note here, so it is not looked at.
          START: state <= WAIT;
          WAIT: begin
            if (dur_done) begin
              tone_en  <= 1'b0;
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: 1-cycle ROM, behavioural duration timer, event schedule model.
module tb_note_sequencer;

  localparam int ADDR_W = 2;
  localparam int NOTES  = 4;
`ifdef LOOP_SONG_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic [7:0]  dur;
  logic        note_start;
  logic        dur_done;
  logic [7:0]  pitch;
  logic        tone_en;
  logic        playing;
  logic        song_end;

  logic [15:0] rom [NOTES];
  logic [7:0]  tcnt = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  typedef struct {
    bit         is_end;
    logic [7:0] p;
    logic [7:0] d;
    int         at;
  } ev_t;
  ev_t q[$];

  note_sequencer #(.ADDR_W(ADDR_W), .PITCH_W(8), .DUR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .play(play), .stop(stop),
    .rom_addr(rom_addr), .rom_data(rom_data), .dur(dur), .note_start(note_start),
    .dur_done(dur_done), .pitch(pitch), .tone_en(tone_en), .playing(playing),
    .song_end(song_end)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Duration timer: done is a level that stays high once the count expires.
  always @(posedge clk) begin
    if (note_start) tcnt <= dur;
    else if (tcnt != 0) tcnt <= tcnt - 8'd1;
  end
  assign dur_done = (tcnt == 8'd0);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, exp);
    end
  endtask

  // Monitor: pops the scheduled event whenever the DUT shows note_start or song_end.
  always @(negedge clk) begin
    ev_t e;
    while (q.size() > 0 && q[0].at < cyc) begin
      chk("missing_event", 32'(q[0].at), 32'(cyc));
      void'(q.pop_front());
    end
    if (note_start || song_end) begin
      if (q.size() == 0 || q[0].at != cyc) begin
        chk("unexpected_event", {30'd0, note_start, song_end}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("event_kind", {31'd0, song_end}, {31'd0, e.is_end});
        if (e.is_end) begin
          chk("end_tone_en", {31'd0, tone_en}, 32'd0);
        end else begin
          chk("note_pitch", {24'd0, pitch}, {24'd0, e.p});
          chk("note_dur", {24'd0, dur}, {24'd0, e.d});
          chk("note_tone_en", {31'd0, tone_en}, {31'd0, (e.p != 8'd0)});
          chk("note_playing", {31'd0, playing}, 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Schedule from the song rules: a fetch cycle f yields its note or end marker at f+2;
  // a note of length d starting at s finishes (done seen) at s+d+1 and the next fetch follows.
  task automatic gen(input int p);
    int addr = 0;
    int f = p + 1;
    int ends = 0;
    int s, w;
    while (1) begin
      if (rom[addr][7:0] == 8'd0) begin
        q.push_back('{is_end: 1'b1, p: 8'd0, d: 8'd0, at: f + 2});
        ends++;
        if (!LOOP || ends >= 2) break;
        f = f + 2;
        addr = 0;
      end else begin
        s = f + 2;
        q.push_back('{is_end: 1'b0, p: rom[addr][15:8], d: rom[addr][7:0], at: s});
        w = s + int'(rom[addr][7:0]) + 1;
        if (addr == NOTES - 1) begin
          q.push_back('{is_end: 1'b1, p: 8'd0, d: 8'd0, at: w + 1});
          ends++;
          if (!LOOP || ends >= 2) break;
          f = w + 1;
          addr = 0;
        end else begin
          addr++;
          f = w + 1;
        end
      end
    end
  endtask

  task automatic start_song(output int p);
    p = cyc;
    gen(p);
    play = 1'b1;
    tick();
    play = 1'b0;
  endtask

  task automatic do_stop();
    int k = cyc;
    while (q.size() > 0 && q[q.size()-1].at > k) void'(q.pop_back());
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    while (q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic finish_song();
    if (LOOP) do_stop();
    tick();
    chk("idle_after_song", {31'd0, playing}, 32'd0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int p;
    for (int i = 0; i < NOTES; i++) rom[i] = '0;

    // Reset values
    #12;
    chk("rst_outputs", {rom_addr, dur, pitch, note_start, tone_en, playing, song_end}, 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("idle_no_play", {31'd0, playing}, 32'd0);
    chk("idle_addr", {30'd0, rom_addr}, 32'd0);

    // Note, rest, end marker
    rom[0] = {8'h40, 8'd10};
    rom[1] = {8'h00, 8'd5};
    rom[2] = {8'h77, 8'd0};
    rom[3] = {8'h11, 8'd3};
    start_song(p);
    wait_drain(500);
    finish_song();

    // Stop during the first note
    rom[0] = {8'h23, 8'd6};
    rom[1] = {8'h24, 8'd4};
    start_song(p);
    wait_until(p + 5);
    do_stop();
    chk("stop_playing", {31'd0, playing}, 32'd0);
    chk("stop_outputs", {16'd0, tone_en, note_start, dur, pitch[5:0]}, 32'd0);
    chk("stop_pitch", {24'd0, pitch}, 32'd0);
    repeat (20) tick();

    // play and stop together, then play while playing
    play = 1'b1;
    stop = 1'b1;
    tick();
    play = 1'b0;
    stop = 1'b0;
    chk("play_stop_same", {31'd0, playing}, 32'd0);
    repeat (10) tick();
    rom[0] = {8'h31, 8'd8};
    rom[1] = {8'h32, 8'd2};
    rom[2] = {8'h00, 8'd0};
    start_song(p);
    wait_until(p + 6);
    begin
      logic [ADDR_W-1:0] a0;
      a0 = rom_addr;
      play = 1'b1;
      tick();
      play = 1'b0;
      chk("replay_addr", {30'd0, rom_addr}, {30'd0, a0});
    end
    wait_drain(500);
    finish_song();

    // Address wrap: every entry is a note
    for (int i = 0; i < NOTES; i++) rom[i] = {8'(8'h50 + i), 8'(i + 2)};
    start_song(p);
    wait_drain(500);
    if (LOOP) begin
      chk("loop_addr", {30'd0, rom_addr}, 32'd0);
      chk("loop_playing", {31'd0, playing}, 32'd1);
    end else begin
      chk("wrap_addr", {30'd0, rom_addr}, 32'(NOTES - 1));
    end
    finish_song();

    // Async reset in the middle of a note
    rom[0] = {8'h61, 8'd8};
    start_song(p);
    wait_until(p + 6);
    reset_n = 1'b0;
    #1;
    chk("async_rst", {rom_addr, dur, pitch, note_start, tone_en, playing, song_end}, 32'd0);
    q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    repeat (15) tick();
    chk("post_rst_idle", {31'd0, playing}, 32'd0);

    // Random songs, some cut short by stop
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NOTES; i++) begin
        rom[i][7:0]  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
        rom[i][15:8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      start_song(p);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 30)) tick();
        do_stop();
        chk("rand_stop_idle", {31'd0, playing}, 32'd0);
        repeat (8) tick();
        wait_drain(50);
      end else begin
        wait_drain(500);
        finish_song();
      end
      repeat ($urandom_range(2, 4)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
